// File: rtl/iir_z2r_arbiter_if.sv
// Requester / result bus for iir_z2r_arbiter.
//   req_valid/req_ready : one valid/ready pair per requester
//   req_data            : requester i word at [16i+15:16i], two's complement
//   out_valid/out_ready : result handshake
//   out_data            : IEEE-754 single {sign, exp[7:0], frac[22:0]}
//   out_id              : requester index that produced out_data
// master = requesters + downstream consumer, slave = the arbiter.
interface iir_z2r_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic [ID_W-1:0]       out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/iir_z2r_arbiter.sv
// Round-robin arbiter in front of a shared int16 -> float32 converter.
// Two pipeline stages: S1 captures the granted word, S2 holds the converted result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : iir_z2r_arbiter_if slave (requests in, converted result out)
//   busy  : high while either stage holds data
module iir_z2r_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  iir_z2r_arbiter_if.slave      bus,
  output logic                  busy
);

  // Exact conversion: a 16-bit magnitude always fits in the 24-bit significand.
  function automatic logic [31:0] int_to_f32(input logic [15:0] d);
    logic [15:0] mag;
    logic [3:0]  p;
    logic [23:0] norm;
    logic [7:0]  exp;
    mag = d[15] ? (~d + 16'd1) : d;  // -32768 wraps to 0x8000, which is the right magnitude
    p = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      if (mag[b]) p = 4'(b);           // highest set bit wins
    end
    norm = {8'b0, mag} << (5'd23 - {1'b0, p});
    exp  = 8'd127 + {4'b0, p};
    return (mag == 16'd0) ? 32'd0 : {d[15], exp, norm[22:0]};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [15:0]     s1_data_q, s1_data_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            s2_adv;
  logic            s1_free;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [15:0]     grant_data;
  logic            handshake;

  assign s2_adv    = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign s1_free   = ~s1_valid_q | s2_adv;
  assign handshake = grant_found & s1_free;

  // Search from ptr, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && bus.req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) grant_data = bus.req_data[k*16 +: 16];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_found) bus.req_ready[grant_idx] = s1_free;
  end

  // Next state for S1, pointer and S2.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    if (handshake) begin
      s1_valid_d = 1'b1;
      s1_data_d  = grant_data;
      s1_id_d    = grant_idx;
      ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = int_to_f32(s1_data_q);
      out_id_d    = s1_id_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign busy          = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_iir_z2r_arbiter.sv
// Directed bench for iir_z2r_arbiter with hand-computed float32 results.
module tb_iir_z2r_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_errors;

  iir_z2r_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  iir_z2r_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single word from requester id with downstream always ready.
  task automatic send_check(input int id, input logic [15:0] d, input logic [31:0] exp_f);
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_data[id*16 +: 16] = d;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'(1) << id);
    @(negedge clk);
    bus.req_valid = '0;
    check("single_lat_ov0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("single_ov", 32'(bus.out_valid), 32'd1);
    check("single_data", bus.out_data, exp_f);
    check("single_id", 32'(bus.out_id), 32'(id));
  endtask

  initial begin
    logic [31:0] rr_f [4];
    logic [15:0] bp_vals [4];
    logic [31:0] bp_f [4];
    int          k;
    int          accepted;

    n_checks = 0;
    n_errors = 0;
    rr_f    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    bp_vals = '{16'h0005, 16'hFFFE, 16'h0007, 16'h0009};
    bp_f    = '{32'h40A00000, 32'hC0000000, 32'h40E00000, 32'h41100000};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;

    // Single conversions and boundaries
    send_check(0, 16'h0001, 32'h3F800000);
    send_check(0, 16'hFFFF, 32'hBF800000);
    send_check(0, 16'h0003, 32'h40400000);
    send_check(0, 16'h0064, 32'h42C80000);
    send_check(0, 16'h0000, 32'h00000000);
    send_check(0, 16'h8000, 32'hC7000000);
    send_check(0, 16'h7FFF, 32'h46FFFE00);

    // Round robin, all four requesters valid, ptr starts at 0
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'(i + 1);
    bus.req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c < 6) check("rr_grant", 32'(bus.req_ready), 32'(1) << (c % 4));
      if (c >= 2) begin
        check("rr_out_valid", 32'(bus.out_valid), 32'd1);
        check("rr_out_id", 32'(bus.out_id), 32'((c - 2) % 4));
        check("rr_out_data", bus.out_data, rr_f[(c - 2) % 4]);
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    check("rr_drained", 32'(busy), 32'd0);

    // Backpressure: requester 2 streams with out_ready low
    bus.out_ready = 1'b0;
    k = 0;
    accepted = 0;
    bus.req_valid[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.req_data[2*16 +: 16] = bp_vals[k];
      #1;
      if (bus.req_ready[2]) begin
        accepted++;
        k++;
      end
      @(negedge clk);
    end
    check("bp_accepts", 32'(accepted), 32'd2);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready_low", 32'(bus.req_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_data", bus.out_data, bp_f[0]);
      check("bp_hold_id", 32'(bus.out_id), 32'd2);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_first_data", bus.out_data, bp_f[0]);
    @(negedge clk);
    check("bp_second_valid", 32'(bus.out_valid), 32'd1);
    check("bp_second_data", bus.out_data, bp_f[1]);
    check("bp_second_id", 32'(bus.out_id), 32'd2);
    @(negedge clk);
    check("bp_no_dup", 32'(bus.out_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);

    // Pointer skip: bring ptr to 2, then requesters 1 and 3 compete
    do_reset();
    send_check(1, 16'h0002, 32'h40000000);
    @(negedge clk);
    bus.req_data[1*16 +: 16] = 16'h0002;
    bus.req_data[3*16 +: 16] = 16'h0004;
    bus.req_valid = 4'b1010;
    #1;
    check("skip_grant3", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    check("skip_grant1", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    check("skip_id3", 32'(bus.out_id), 32'd3);
    check("skip_data3", bus.out_data, 32'h40800000);
    @(negedge clk);
    check("skip_id1", 32'(bus.out_id), 32'd1);
    check("skip_data1", bus.out_data, 32'h40000000);

    // Reset while both stages are full
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req_data[0 +: 16] = 16'h0003;
    bus.req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'(16'h0064 + i);
    bus.req_valid = 4'hF;
    #1;
    check("mid_first_grant", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    check("mid_out_valid_after", 32'(bus.out_valid), 32'd1);
    check("mid_out_id", 32'(bus.out_id), 32'd0);
    check("mid_out_data", bus.out_data, 32'h42C80000);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
